// File: rtl/alu_result_collector.sv
// alu_result_collector: latches the 64-bit ALU result and streams it as 32-bit valid/ready beats, committing HI/LO for mul/div.
// Optional ALU_RESULT_FLAGS_EN adds zero_flag/neg_flag registered at capture.
module alu_result_collector #(
  parameter int DATA_W = 32,
  parameter logic [4:0] OPC_MUL = 5'b01110,
  parameter logic [4:0] OPC_DIV = 5'b01111,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [2*DATA_W-1:0] alu_result,
  input  logic [4:0]          opcode,
  input  logic                capture,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                busy,
  output logic [DATA_W-1:0]   hi_reg,
  output logic [DATA_W-1:0]   lo_reg,
  output logic                drop_err,
  output logic [CNT_W-1:0]    result_count
`ifdef ALU_RESULT_FLAGS_EN
  ,
  output logic                zero_flag,
  output logic                neg_flag
`endif
);
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
  state_t state;
  logic [2*DATA_W-1:0] z;
  logic [4:0] op;
  logic hs, two, complete, accept;
  always_comb begin
    hs = bus_valid & bus_ready;
    two = (op == OPC_MUL) || (op == OPC_DIV);
    complete = hs && (state == SEND_HI || (state == SEND_LO && !two));
    accept = capture && (state == IDLE || complete);
  end
`ifdef ALU_RESULT_FLAGS_EN
  logic in_two;
  assign in_two = (opcode == OPC_MUL) || (opcode == OPC_DIV);
`endif
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      z <= '0;
      op <= '0;
      bus_out <= '0;
      bus_valid <= 1'b0;
      busy <= 1'b0;
      hi_reg <= '0;
      lo_reg <= '0;
      drop_err <= 1'b0;
      result_count <= '0;
`ifdef ALU_RESULT_FLAGS_EN
      zero_flag <= 1'b0;
      neg_flag <= 1'b0;
`endif
    end else begin
      // a completing handshake may accept the next capture with no bubble
      if (accept) begin
        state <= SEND_LO;
        z <= alu_result;
        op <= opcode;
        bus_out <= alu_result[DATA_W-1:0];
        bus_valid <= 1'b1;
        busy <= 1'b1;
`ifdef ALU_RESULT_FLAGS_EN
        zero_flag <= in_two ? (alu_result == '0) : (alu_result[DATA_W-1:0] == '0);
        neg_flag <= in_two ? alu_result[2*DATA_W-1] : alu_result[DATA_W-1];
`endif
      end else if (complete) begin
        state <= IDLE;
        bus_valid <= 1'b0;
        busy <= 1'b0;
      end else if (hs && state == SEND_LO) begin
        state <= SEND_HI;
        bus_out <= z[2*DATA_W-1:DATA_W];
      end
      if (complete) result_count <= result_count + CNT_W'(1);
      if (complete && state == SEND_HI) begin
        hi_reg <= z[2*DATA_W-1:DATA_W];
        lo_reg <= z[DATA_W-1:0];
      end
      if (capture && !accept) drop_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed vectors with hand-computed expectations for alu_result_collector.
module tb_alu_result_collector;
  logic clk = 1'b0;
  logic clr, capture, bus_ready;
  logic [63:0] alu_result;
  logic [4:0] opcode;
  logic [31:0] bus_out, hi_reg, lo_reg;
  logic bus_valid, busy, drop_err;
  logic [7:0] result_count;
  int checks = 0;
  int failures = 0;

  alu_result_collector dut (
    .clk(clk), .clr(clr), .alu_result(alu_result), .opcode(opcode), .capture(capture),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_ready(bus_ready), .busy(busy),
    .hi_reg(hi_reg), .lo_reg(lo_reg), .drop_err(drop_err), .result_count(result_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; capture = 1'b0; bus_ready = 1'b0; alu_result = '0; opcode = '0;
    tick(); tick();
    clr = 1'b0;
    chk("rst_valid", bus_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_hi", hi_reg, 0);
    chk("rst_lo", lo_reg, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_cnt", result_count, 0);

    // single-beat shra
    bus_ready = 1'b1; alu_result = 64'h00000000FFFFFFFD; opcode = 5'b10010; capture = 1'b1;
    tick();
    capture = 1'b0;
    chk("t1_valid", bus_valid, 1);
    chk("t1_bus", bus_out, 32'hFFFFFFFD);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_valid_off", bus_valid, 0);
    chk("t1_cnt", result_count, 1);
    chk("t1_hi", hi_reg, 0);
    chk("t1_lo", lo_reg, 0);

    // two-beat mul with backpressure
    bus_ready = 1'b0; alu_result = 64'hFFFFFFFFFFFFFFEA; opcode = 5'b01110; capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_lo_hold", bus_out, 32'hFFFFFFEA);
      chk("t2_valid_hold", bus_valid, 1);
      tick();
    end
    bus_ready = 1'b1;
    chk("t2_lo_hold4", bus_out, 32'hFFFFFFEA);
    tick();
    chk("t2_hi_beat", bus_out, 32'hFFFFFFFF);
    chk("t2_valid_hi", bus_valid, 1);
    chk("t2_lo_precommit", lo_reg, 0);
    chk("t2_cnt_mid", result_count, 1);
    tick();
    chk("t2_lo_reg", lo_reg, 32'hFFFFFFEA);
    chk("t2_hi_reg", hi_reg, 32'hFFFFFFFF);
    chk("t2_cnt", result_count, 2);
    chk("t2_valid_off", bus_valid, 0);

    // back-to-back capture on completing handshake
    alu_result = 64'h0000000000000011; opcode = 5'b00000; capture = 1'b1;
    tick();
    alu_result = 64'hABCD000000000022; opcode = 5'b00001;
    chk("t4_first", bus_out, 32'h00000011);
    tick();
    capture = 1'b0;
    chk("t4_valid_kept", bus_valid, 1);
    chk("t4_second", bus_out, 32'h00000022);
    chk("t4_cnt", result_count, 3);
    chk("t4_no_drop", drop_err, 0);
    tick();
    chk("t4_valid_off", bus_valid, 0);
    chk("t4_cnt2", result_count, 4);
    chk("t4_hi_untouched", hi_reg, 32'hFFFFFFFF);
    chk("t4_lo_untouched", lo_reg, 32'hFFFFFFEA);

    // capture while stalled in SEND_LO is dropped
    bus_ready = 1'b0; alu_result = 64'h0000000000001234; opcode = 5'b00011; capture = 1'b1;
    tick();
    alu_result = 64'h0000000000005555;
    tick();
    capture = 1'b0;
    chk("t3_bus_kept", bus_out, 32'h00001234);
    chk("t3_drop", drop_err, 1);
    bus_ready = 1'b1;
    tick();
    chk("t3_cnt", result_count, 5);
    chk("t3_valid_off", bus_valid, 0);
    tick();
    chk("t3_drop_sticky", drop_err, 1);

    // clr during SEND_HI of a div
    alu_result = 64'h0000000100000005; opcode = 5'b01111; capture = 1'b1; bus_ready = 1'b0;
    tick();
    capture = 1'b0; bus_ready = 1'b1;
    chk("t5_lo_beat", bus_out, 32'h00000005);
    tick();
    bus_ready = 1'b0;
    chk("t5_hi_beat", bus_out, 32'h00000001);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_valid", bus_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_bus", bus_out, 0);
    chk("t5_hi", hi_reg, 0);
    chk("t5_lo", lo_reg, 0);
    chk("t5_drop", drop_err, 0);
    chk("t5_cnt", result_count, 0);
    bus_ready = 1'b1;
    tick();
    chk("t5_hi_after", hi_reg, 0);
    chk("t5_cnt_after", result_count, 0);
    chk("t5_idle", bus_valid, 0);

    // 256 completed results wrap the counter
    alu_result = 64'h0000000000000007; opcode = 5'b00000; capture = 1'b1;
    for (int i = 0; i < 256; i++) tick();
    chk("t6_cnt255", result_count, 8'd255);
    chk("t6_valid", bus_valid, 1);
    capture = 1'b0;
    tick();
    chk("t6_wrap", result_count, 0);
    chk("t6_valid_off", bus_valid, 0);
    chk("t6_no_drop", drop_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
